// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter controller with branch/jump/exception/halt sequencing
// Misaligned redirect targets trap instead of loading pc; exceptions raised under stall are held pending.
module pc_ctrl #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80),
  parameter logic [WIDTH-1:0] STEP      = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] badaddr,
  output logic             exc_ack,
  output logic             halted
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] HALT = 2'd1;
  localparam logic [1:0] TRAP = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] r_badaddr;
  logic             r_pend;

  logic             w_exc;
  logic             w_tgt_sel;
  logic [WIDTH-1:0] w_tgt;
  logic             w_misal;
  logic [WIDTH-1:0] w_pc_plus;

  assign w_exc     = exc_req | r_pend;
  assign w_pc_plus = r_pc + STEP;

  // eret outranks jmp, which outranks a taken branch
  always_comb begin
    w_tgt_sel = 1'b1;
    w_tgt     = r_epc;
    if (eret) begin
      w_tgt = r_epc;
    end else if (jmp) begin
      w_tgt = jmp_target;
    end else if (br_taken) begin
      w_tgt = br_target;
    end else begin
      w_tgt_sel = 1'b0;
    end
  end

  assign w_misal = w_tgt_sel && (w_tgt[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_pc      <= RESET_VEC;
      r_epc     <= '0;
      r_badaddr <= '0;
      r_pend    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (stall) begin
            if (exc_req) r_pend <= 1'b1;
          end else if (w_exc || w_misal) begin
            r_epc   <= r_pc;
            r_pc    <= EXC_VEC;
            r_state <= TRAP;
            r_pend  <= 1'b0;
            if (!w_exc) r_badaddr <= w_tgt;
          end else if (w_tgt_sel) begin
            r_pc <= w_tgt;
          end else if (halt_req) begin
            r_state <= HALT;
          end else begin
            r_pc <= w_pc_plus;
          end
        end
        HALT: begin
          if (stall) begin
            if (exc_req) r_pend <= 1'b1;
          end else if (w_exc) begin
            r_epc   <= r_pc;
            r_pc    <= EXC_VEC;
            r_state <= TRAP;
            r_pend  <= 1'b0;
          end else if (resume) begin
            r_pc    <= w_pc_plus;
            r_state <= RUN;
          end
        end
        TRAP: begin
          // the TRAP cycle fetched EXC_VEC, so the handler continues sequentially
          r_pc    <= w_pc_plus;
          r_state <= RUN;
          if (exc_req) r_pend <= 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign pc      = r_pc;
  assign pc_plus = w_pc_plus;
  assign epc     = r_epc;
  assign badaddr = r_badaddr;
  assign exc_ack = (r_state == TRAP);
  assign halted  = (r_state == HALT);

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, sets the PC/address width in bits (minimum 8).
REQ-002 Parameter RESET_VEC, default 0, is the PC value after reset.
REQ-003 Parameter EXC_VEC, default 'h80, is the exception handler entry address.
REQ-004 Parameter STEP, default 4, is the sequential increment.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 stall  in  1  hold all state this cycle, except that exc_req is captured as pending.
REQ-008 br_taken  in  1  conditional branch is taken.
REQ-009 br_target  in  WIDTH  branch destination.
REQ-010 jmp  in  1  unconditional jump or jump-register.
REQ-011 jmp_target  in  WIDTH  jump destination.
REQ-012 exc_req  in  1  synchronous exception request, single-cycle pulse.
REQ-013 eret  in  1  return from exception.
REQ-014 halt_req  in  1  enter HALT.
REQ-015 resume  in  1  leave HALT.
REQ-016 pc  out  WIDTH  current fetch address, registered.
REQ-017 pc_plus  out  WIDTH  pc+STEP, combinational.
REQ-018 epc  out  WIDTH  saved exception PC, registered.
REQ-019 badaddr  out  WIDTH  offending target of the last misalignment trap, registered.
REQ-020 exc_ack  out  1  high for exactly the one cycle spent in TRAP.
REQ-021 halted  out  1  high while in HALT.

Function
REQ-022 FSM states SHALL be RUN, HALT and TRAP; the reset state is RUN.
REQ-023 In RUN with stall=0, next pc SHALL be chosen by priority:
- exc_req or pending exception -> EXC_VEC
- eret -> epc
- jmp -> jmp_target
- br_taken -> br_target
- otherwise pc+STEP
REQ-024 All additions SHALL be modulo 2^WIDTH; pc+STEP from the top address SHALL wrap to 0 with no flag.
REQ-025 Exception entry SHALL set epc<=pc (the current, not next, pc), pc<=EXC_VEC and state<=TRAP.
REQ-026 A selected jmp/br/eret target with its low two bits nonzero SHALL NOT load pc; it SHALL instead:
- perform exception entry
- set badaddr<=that target
REQ-027 TRAP SHALL last one cycle with pc held at EXC_VEC and exc_ack=1, then go to RUN; stall is ignored in TRAP.
REQ-028 With stall=1 in RUN, pc, epc and state SHALL hold; an exc_req SHALL set a pending flag, which is serviced on the first unstalled RUN cycle and then cleared.
REQ-029 halt_req in RUN, stall=0 and no exception: state<=HALT and pc holds; if exc_req is also high, the exception wins and halt_req is dropped.
REQ-030 In HALT, pc SHALL hold and halted=1.
- resume: pc<=pc+STEP, state<=RUN
- exc_req: perform exception entry (epc<=pc), go to TRAP
- exc_req and resume together: the exception wins
REQ-031 eret and jmp together SHALL take eret; pending exception and eret together SHALL take the exception.

Reset
REQ-032 rst=0 SHALL immediately force: pc=RESET_VEC, epc=0, badaddr=0, pending=0, state=RUN, exc_ack=0, halted=0.
REQ-033 Reset asserted mid-TRAP or mid-HALT SHALL discard all in-flight state; the first edge after release loads RESET_VEC+STEP.
REQ-034 Reset release SHALL be synchronous to clk from the design's view; bench deasserts rst away from the clock edge.

Verification
REQ-035 Sequential run with WIDTH=32: reset, then 3 edges -> pc 0,4,8,12; pc_plus is always pc+4.
REQ-036 Priority: at pc=0x10 assert jmp=1 (0x40) and br_taken=1 (0x80) -> pc=0x40; then eret with jmp -> pc=epc.
REQ-037 Exception under stall:
- exc_req pulse at pc=0x20 while stall=1 for 3 cycles -> pc stays 0x20
- on release: pc=0x80, epc=0x20, exc_ack=1 for one cycle
- then pc=0x84
REQ-038 Misalignment: br_taken with br_target=0x42 at pc=0x30 -> pc=0x80, epc=0x30, badaddr=0x42.
REQ-039 Halt: halt_req at pc=0x8 -> halted=1, pc=0x8 for 5 cycles; resume -> pc=0xC; with WIDTH=16 and pc=0xFFFC, sequential step -> pc=0x0000.
REQ-040 Asynchronous reset asserted mid-TRAP, between edges -> pc=RESET_VEC and exc_ack=0 immediately.
